// File: rtl/load_sequencer.sv
// Load-window and ring-address sequencer for the SNN time-step path.
// Produces a periodic en_load window, a one-cycle step event at each window's
// falling edge, and a write/read ring address pair kept DELAY entries apart.
//
// state | meaning
// IDLE  | stopped, waiting for start; outputs hold, en_load low
// RUN   | phase counting, windows and step events generated
// DONE  | TOTAL+1 steps completed (STOP_ON_DONE), frozen until start
module load_sequencer #(
  parameter int ADDR_W       = 4,
  parameter int PERIOD       = 8,
  parameter int LOAD_START   = 2,
  parameter int LOAD_LEN     = 2,
  parameter int DELAY        = 1,
  parameter int WARMUP       = 16,
  parameter int TOTAL        = 320,
  parameter int CNT_W        = 10,
  parameter bit AUTO_START   = 1'b1,
  parameter bit STOP_ON_DONE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              en_load,
  output logic              step,
  output logic [ADDR_W-1:0] addr_w,
  output logic [ADDR_W-1:0] addr_r,
  output logic [CNT_W-1:0]  step_cnt,
  output logic              warm,
  output logic              done,
  output logic              busy
);

  localparam int PH_W = $clog2(PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam state_t            RST_STATE = AUTO_START ? S_RUN : S_IDLE;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0]   WIN_LO    = PH_W'(LOAD_START);
  localparam logic [PH_W-1:0]   WIN_HI    = PH_W'(LOAD_START + LOAD_LEN - 1);
  localparam logic [ADDR_W-1:0] FILL_END  = ADDR_W'(DELAY);
  localparam logic [CNT_W-1:0]  CNT_WARM  = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(TOTAL);

  state_t            state, state_nx;
  logic [PH_W-1:0]   phase, phase_nx;
  logic [ADDR_W-1:0] fill, fill_nx;
  logic [ADDR_W-1:0] addr_w_nx, addr_r_nx;
  logic [CNT_W-1:0]  step_cnt_nx;
  logic              en_load_nx, step_nx, warm_nx, done_nx, busy_nx;

  // Next-state and next-output computation; every output is registered from
  // these so en_load lines up with the phase it describes.
  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    fill_nx     = fill;
    addr_w_nx   = addr_w;
    addr_r_nx   = addr_r;
    step_cnt_nx = step_cnt;
    warm_nx     = warm;
    done_nx     = done;
    step_nx     = 1'b0;
    case (state)
      S_RUN: begin
        if (stop) begin
          // stop wins over a coincident step edge: the window is abandoned
          state_nx = S_IDLE;
          phase_nx = '0;
        end else begin
          phase_nx = (phase == PH_LAST) ? '0 : phase + 1'b1;
          if (phase == WIN_HI) begin
            step_nx     = 1'b1;
            step_cnt_nx = step_cnt + 1'b1;
            // read pointer runs ahead alone until the ring holds DELAY entries
            if (fill < FILL_END) begin
              fill_nx   = fill + 1'b1;
              addr_r_nx = addr_r + 1'b1;
            end else begin
              addr_r_nx = addr_r + 1'b1;
              addr_w_nx = addr_w + 1'b1;
            end
            if (step_cnt == CNT_WARM) warm_nx = 1'b1;
            if (step_cnt == CNT_DONE) begin
              done_nx = 1'b1;
              if (STOP_ON_DONE) begin
                state_nx = S_DONE;
                phase_nx = '0;
              end
            end
          end
        end
      end
      default: begin
        phase_nx = '0;
        if (start) begin
          state_nx    = S_RUN;
          fill_nx     = '0;
          addr_w_nx   = '0;
          addr_r_nx   = '0;
          step_cnt_nx = '0;
          warm_nx     = 1'b0;
          done_nx     = 1'b0;
        end
      end
    endcase
    en_load_nx = (state_nx == S_RUN) && (phase_nx >= WIN_LO) && (phase_nx <= WIN_HI);
    busy_nx    = (state_nx == S_RUN);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RST_STATE;
      phase    <= '0;
      fill     <= '0;
      addr_w   <= '0;
      addr_r   <= '0;
      step_cnt <= '0;
      en_load  <= 1'b0;
      step     <= 1'b0;
      warm     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      fill     <= fill_nx;
      addr_w   <= addr_w_nx;
      addr_r   <= addr_r_nx;
      step_cnt <= step_cnt_nx;
      en_load  <= en_load_nx;
      step     <= step_nx;
      warm     <= warm_nx;
      done     <= done_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: four parameterisations share clock and controls;
// each scenario task checks one instance cycle by cycle against a closed-form
// model derived from the cycle index since the run began.
module tb_load_sequencer;

  localparam int P  = 8;
  localparam int LO = 2;
  localparam int HI = 3;

  logic clk = 1'b0;
  logic rst, start, stop;

  always #5 clk = ~clk;

  // defaults
  logic d_en, d_step, d_warm, d_done, d_busy;
  logic [3:0] d_aw, d_ar;
  logic [9:0] d_cnt;
  // ADDR_W=3, DELAY=3
  logic y_en, y_step, y_warm, y_done, y_busy;
  logic [2:0] y_aw, y_ar;
  logic [9:0] y_cnt;
  // STOP_ON_DONE=0, TOTAL=5, CNT_W=3, WARMUP=2
  logic s_en, s_step, s_warm, s_done, s_busy;
  logic [3:0] s_aw, s_ar;
  logic [2:0] s_cnt;
  // AUTO_START=0
  logic m_en, m_step, m_warm, m_done, m_busy;
  logic [3:0] m_aw, m_ar;
  logic [9:0] m_cnt;

  load_sequencer u_def (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en_load(d_en), .step(d_step), .addr_w(d_aw), .addr_r(d_ar),
    .step_cnt(d_cnt), .warm(d_warm), .done(d_done), .busy(d_busy));

  load_sequencer #(.ADDR_W(3), .DELAY(3)) u_dly (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en_load(y_en), .step(y_step), .addr_w(y_aw), .addr_r(y_ar),
    .step_cnt(y_cnt), .warm(y_warm), .done(y_done), .busy(y_busy));

  load_sequencer #(.STOP_ON_DONE(1'b0), .TOTAL(5), .CNT_W(3), .WARMUP(2)) u_sod (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en_load(s_en), .step(s_step), .addr_w(s_aw), .addr_r(s_ar),
    .step_cnt(s_cnt), .warm(s_warm), .done(s_done), .busy(s_busy));

  load_sequencer #(.AUTO_START(1'b0)) u_man (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en_load(m_en), .step(m_step), .addr_w(m_aw), .addr_r(m_ar),
    .step_cnt(m_cnt), .warm(m_warm), .done(m_done), .busy(m_busy));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic en;
    logic stp;
    logic busy;
    logic warm;
    logic done;
    int   n;
  } exp_t;

  // Expected outputs in cycle k of a run (k=0 is phase 0). n is the number of
  // step edges already taken; a run launched by reset release shows reset
  // values (busy low) in its first cycle.
  function automatic exp_t model(int k, int warmup, int total, bit sod, bit from_reset);
    exp_t e;
    int   n_raw;
    n_raw  = (k > HI) ? (k - 1 - HI) / P + 1 : 0;
    e.stp  = (k > HI) && (((k - 1 - HI) % P) == 0);
    e.en   = ((k % P) >= LO) && ((k % P) <= HI);
    e.busy = !(from_reset && k == 0);
    e.n    = n_raw;
    if (sod && n_raw > total) begin
      e.n    = total + 1;
      e.en   = 1'b0;
      e.busy = 1'b0;
      if (n_raw > total + 1) e.stp = 1'b0;
    end
    e.warm = (e.n > warmup);
    e.done = (e.n > total);
    return e;
  endfunction

  function automatic int wexp(int n, int dly);
    return (n > dly) ? n - dly : 0;
  endfunction

  task automatic do_reset();
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_en, d_step, d_aw, d_ar, d_cnt, d_warm, d_done, d_busy} !== 23'd0) begin
      errors++; $display("FAIL reset_def got %h exp 0", {d_en, d_step, d_aw, d_ar, d_cnt, d_warm, d_done, d_busy});
    end
    checks++;
    if ({y_en, y_step, y_aw, y_ar, y_cnt, y_warm, y_done, y_busy} !== 21'd0) begin
      errors++; $display("FAIL reset_dly got %h exp 0", {y_en, y_step, y_aw, y_ar, y_cnt, y_warm, y_done, y_busy});
    end
    checks++;
    if ({s_en, s_step, s_aw, s_ar, s_cnt, s_warm, s_done, s_busy} !== 16'd0) begin
      errors++; $display("FAIL reset_sod got %h exp 0", {s_en, s_step, s_aw, s_ar, s_cnt, s_warm, s_done, s_busy});
    end
    checks++;
    if ({m_en, m_step, m_aw, m_ar, m_cnt, m_warm, m_done, m_busy} !== 23'd0) begin
      errors++; $display("FAIL reset_man got %h exp 0", {m_en, m_step, m_aw, m_ar, m_cnt, m_warm, m_done, m_busy});
    end
  endtask

  // Covers the en_load pattern, first step, (w,r) sequence, warm/done, freeze;
  // then a start from DONE must restart cleanly.
  task automatic test_flags();
    exp_t e;
    logic [22:0] ev, av;
    do_reset();
    for (int k = 0; k < 321 * P + 24; k++) begin
      e  = model(k, 16, 320, 1'b1, 1'b1);
      ev = {e.en, e.stp, 4'(wexp(e.n, 1)), 4'(e.n), 10'(e.n), e.warm, e.done, e.busy};
      av = {d_en, d_step, d_aw, d_ar, d_cnt, d_warm, d_done, d_busy};
      checks++;
      if (av !== ev) begin
        errors++; $display("FAIL flags k=%0d got %h exp %h", k, av, ev);
      end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5 * P; k++) begin
      e  = model(k, 16, 320, 1'b1, 1'b0);
      ev = {e.en, e.stp, 4'(wexp(e.n, 1)), 4'(e.n), 10'(e.n), e.warm, e.done, e.busy};
      av = {d_en, d_step, d_aw, d_ar, d_cnt, d_warm, d_done, d_busy};
      checks++;
      if (av !== ev) begin
        errors++; $display("FAIL restart_after_done k=%0d got %h exp %h", k, av, ev);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_delay_wrap();
    exp_t e;
    logic [20:0] ev, av;
    do_reset();
    for (int k = 0; k < 14 * P; k++) begin
      e  = model(k, 16, 320, 1'b1, 1'b1);
      ev = {e.en, e.stp, 3'(wexp(e.n, 3)), 3'(e.n), 10'(e.n), e.warm, e.done, e.busy};
      av = {y_en, y_step, y_aw, y_ar, y_cnt, y_warm, y_done, y_busy};
      checks++;
      if (av !== ev) begin
        errors++; $display("FAIL delay_wrap k=%0d got %h exp %h", k, av, ev);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_no_stop_on_done();
    exp_t e;
    logic [15:0] ev, av;
    do_reset();
    for (int k = 0; k < 20 * P; k++) begin
      e  = model(k, 2, 5, 1'b0, 1'b1);
      ev = {e.en, e.stp, 4'(wexp(e.n, 1)), 4'(e.n), 3'(e.n), e.warm, e.done, e.busy};
      av = {s_en, s_step, s_aw, s_ar, s_cnt, s_warm, s_done, s_busy};
      checks++;
      if (av !== ev) begin
        errors++; $display("FAIL no_stop_on_done k=%0d got %h exp %h", k, av, ev);
      end
      @(negedge clk);
    end
  endtask

  // First stop lands in phase 2 of the first period; later ones are random
  // (never on the step-edge phase itself).
  task automatic test_stop_restart();
    exp_t e, eh;
    logic [22:0] ev, av;
    int run_len, gap;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      run_len = (t == 0) ? 2 : $urandom_range(3, 60);
      if ((run_len % P) == HI) run_len++;
      for (int k = 0; k <= run_len; k++) begin
        e  = model(k, 16, 320, 1'b1, t == 0);
        ev = {e.en, e.stp, 4'(wexp(e.n, 1)), 4'(e.n), 10'(e.n), e.warm, e.done, e.busy};
        av = {d_en, d_step, d_aw, d_ar, d_cnt, d_warm, d_done, d_busy};
        checks++;
        if (av !== ev) begin
          errors++; $display("FAIL stop_run t=%0d k=%0d got %h exp %h", t, k, av, ev);
        end
        if (k < run_len) @(negedge clk);
      end
      eh   = model(run_len, 16, 320, 1'b1, t == 0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      gap  = $urandom_range(1, 6);
      for (int j = 0; j < gap; j++) begin
        ev = {1'b0, 1'b0, 4'(wexp(eh.n, 1)), 4'(eh.n), 10'(eh.n), eh.warm, eh.done, 1'b0};
        av = {d_en, d_step, d_aw, d_ar, d_cnt, d_warm, d_done, d_busy};
        checks++;
        if (av !== ev) begin
          errors++; $display("FAIL stop_hold t=%0d j=%0d got %h exp %h", t, j, av, ev);
        end
        @(negedge clk);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_manual_start();
    exp_t e;
    logic [22:0] ev, av;
    int idle, last;
    do_reset();
    idle = $urandom_range(5, 20);
    for (int j = 0; j < idle; j++) begin
      av = {m_en, m_step, m_aw, m_ar, m_cnt, m_warm, m_done, m_busy};
      checks++;
      if (av !== 23'd0) begin
        errors++; $display("FAIL manual_idle j=%0d got %h exp 0", j, av);
      end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last = P * $urandom_range(1, 3) + LO;
    for (int k = 0; k <= last; k++) begin
      e  = model(k, 16, 320, 1'b1, 1'b0);
      ev = {e.en, e.stp, 4'(wexp(e.n, 1)), 4'(e.n), 10'(e.n), e.warm, e.done, e.busy};
      av = {m_en, m_step, m_aw, m_ar, m_cnt, m_warm, m_done, m_busy};
      checks++;
      if (av !== ev) begin
        errors++; $display("FAIL manual_run k=%0d got %h exp %h", k, av, ev);
      end
      if (k < last) @(negedge clk);
    end
    #1 rst = 1'b0;
    #1;
    av = {m_en, m_step, m_aw, m_ar, m_cnt, m_warm, m_done, m_busy};
    checks++;
    if (av !== 23'd0) begin
      errors++; $display("FAIL async_reset got %h exp 0", av);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 3 * P; j++) begin
      av = {m_en, m_step, m_aw, m_ar, m_cnt, m_warm, m_done, m_busy};
      checks++;
      if (av !== 23'd0) begin
        errors++; $display("FAIL post_reset_idle j=%0d got %h exp 0", j, av);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    #1;
    test_reset();
    test_flags();
    test_delay_wrap();
    test_no_stop_on_done();
    test_stop_restart();
    test_manual_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
# load_sequencer

Parametrised, fully synchronous successor to the load-strobe and ring-address generator of the SNN time-step path. It produces a periodic `en_load` window with a programmable period and width. It also emits a one-cycle `step` event at each window's falling edge, and keeps a write/read ring-buffer address pair separated by a programmable delay. Warm-up and completion flags mark the run, with start/stop control. It feeds the spike-delay buffers and neuron-update logic.

## Interface
- `ADDR_W`, 4: ring address width; depth 2^ADDR_W.
- `PERIOD`, 8: clocks per time step; ≥2.
- `LOAD_START`, 2: first phase with `en_load`=1.
- `LOAD_LEN`, 2: window length; ≥1, LOAD_START+LOAD_LEN ≤ PERIOD.
- `DELAY`, 1: steady-state addr_r − addr_w (mod 2^ADDR_W); 1..2^ADDR_W−1.
- `WARMUP`, 16: step count at which `warm` rises.
- `TOTAL`, 320: step count at which `done` rises; TOTAL < 2^CNT_W.
- `CNT_W`, 10: step counter width.
- `AUTO_START`, 1: 1 = enter RUN on reset release; 0 = wait for `start`.
- `STOP_ON_DONE`, 1: 1 = go to DONE and freeze; 0 = keep running.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse; honoured in IDLE/DONE only.
- `stop` in 1: honoured in RUN only.
- `en_load` out 1: registered load window.
- `step` out 1: one-cycle step event.
- `addr_w` out ADDR_W: ring write address.
- `addr_r` out ADDR_W: ring read address.
- `step_cnt` out CNT_W: completed steps, wraps.
- `warm` out 1: sticky, pipeline primed.
- `done` out 1: sticky, run complete.
- `busy` out 1: 1 in RUN.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset:**
  - Outputs: all 0, `phase`=0.
  - State: RUN if AUTO_START=1, else IDLE.
- **IDLE/DONE + `start`:** clear `phase`, addresses, `step_cnt`, `fill` count, `warm`, `done`; go to RUN. `stop` is ignored in these states.
- **Phase counter:** in RUN, `phase` counts 0..PERIOD−1 and wraps.
- **`en_load`:** 1 exactly in cycles where LOAD_START ≤ phase < LOAD_START+LOAD_LEN.
- **Step event:** the edge leaving phase LOAD_START+LOAD_LEN−1 while in RUN. At that edge:
  - `step_cnt` += 1.
  - While `fill` < DELAY: only `addr_r` += 1, and `fill` += 1.
  - Otherwise both `addr_r` and `addr_w` += 1.
  - All address arithmetic wraps mod 2^ADDR_W.
  - If pre-increment `step_cnt` == WARMUP: `warm` ← 1.
  - If pre-increment `step_cnt` == TOTAL: `done` ← 1; with STOP_ON_DONE=1, go to DONE.
- **`step`:** high for the one cycle following the step edge, aligned with the updated addresses.
- **RUN + `stop`:** go to IDLE next edge.
  - `en_load` and `phase` clear.
  - Addresses, counters and flags hold.
  - A window cut short by `stop` generates no step event.
- **DONE:** `en_load`=0 and `step`=0 after the final step pulse; addresses hold.
- **STOP_ON_DONE=0:** `done` stays sticky and stepping continues; `step_cnt` wraps at 2^CNT_W without re-asserting anything.
- **Reset mid-run:** immediate return to reset values; no partial step is completed.

## Timing
- **First cycle:** the cycle after reset release (AUTO_START) or after the `start` edge is phase 0.
- **Defaults:**
  - `en_load` high in phases 2–3 of every 8.
  - Step edge at the end of phase 3; `step`=1 and new addresses visible in phase 4.
- **Window ending at PERIOD−1:** `step` lands in phase 0 of the next period.
- **Step output timing:** `warm`, `done` and `busy`→0 (STOP_ON_DONE) change on the step edge, visible with `step`.
- **Latencies:**
  - Output latency is 0 relative to `phase`; all outputs are registered.
  - `start`/`stop` take effect one clock after sampling.
- **Defaults sequence:**
  - Step 1: w=0, r=1.
  - Step 2: w=1, r=2.
  - `warm` rises at step 17.
  - `done` rises at step 321.

## Test plan
- **Defaults, AUTO_START:** release reset → `en_load` pattern 0,0,1,1,0,0,0,0 repeating; first `step` in cycle 4; addr (w,r) = (0,1),(1,2),(2,3).
- **Delay and wrap:** DELAY=3, ADDR_W=3 → r = 1,2,3 with w=0 for 3 steps, then both increment; at step 8 r wraps 7→0 while w=5, and r−w mod 8 = 3 throughout.
- **Flags:** defaults → `warm`=1 from the 17th `step` cycle; `done`=1 and `busy`=0 at the 321st; no further `en_load`; `step_cnt`=321.
- **Stop mid-window:** `stop` in phase 2 → `en_load` 0 next cycle, no `step`, addresses unchanged; `start` → phase 0, counters cleared.
- **STOP_ON_DONE=0, TOTAL=5, CNT_W=3:** `done` sticky from step 6; stepping continues; `step_cnt` wraps 7→0.
- **AUTO_START=0:** no activity until `start`; async `rst` low mid-window → all outputs 0 immediately, state IDLE.
